div_16by16: RTL and testbench

DIV_16BY16 -- requirements
Module: div_16by16

---
 rtl/div_16by16.sv | 112 +++++++++++
 tb/tb_div_16by16.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_16by16.sv
// 16-by-16 unsigned restoring divider: one quotient bit per clock, 16 RUN cycles per operation.
// A zero divisor completes immediately with an all-ones quotient and the dividend as remainder.
module div_16by16 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] dividend_i,
   input  logic [15:0] divisor_i,
   output logic [15:0] quot_o,
   output logic [15:0] rem_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        dz_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [16:0] prem_q;
   logic [15:0] dvd_q;
   logic [15:0] dvs_q;
   logic [3:0]  cnt_q;
   logic [15:0] quot_q;
   logic [15:0] rem_q;
   logic        dz_q;

   logic        accept;
   logic [17:0] shifted;
   logic [17:0] trial;
   logic        neg;
   logic [16:0] prem_nxt;
   logic [15:0] dvd_nxt;

   assign accept = start_i && (state_q != StRun);

   // One restoring step: dvd_q shifts out dividend bits and shifts in quotient bits.
   always_comb begin
      shifted  = {prem_q, dvd_q[15]};
      trial    = shifted - {2'b00, dvs_q};
      neg      = trial[17];
      prem_nxt = neg ? shifted[16:0] : trial[16:0];
      dvd_nxt  = {dvd_q[14:0], ~neg};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = (divisor_i == 16'd0) ? StDone : StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cnt_q == 4'd15) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o = (state_q == StRun);
      done_o = (state_q == StDone);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prem_q <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dz_q   <= 1'b0;
      end else if (accept) begin
         prem_q <= '0;
         dvd_q  <= dividend_i;
         dvs_q  <= divisor_i;
         cnt_q  <= '0;
         if (divisor_i == 16'd0) begin
            quot_q <= 16'hFFFF;
            rem_q  <= dividend_i;
            dz_q   <= 1'b1;
         end
      end else if (state_q == StRun) begin
         prem_q <= prem_nxt;
         dvd_q  <= dvd_nxt;
         cnt_q  <= cnt_q + 4'd1;
         if (cnt_q == 4'd15) begin
            quot_q <= dvd_nxt;
            rem_q  <= prem_nxt[15:0];
            dz_q   <= 1'b0;
         end
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;
   assign dz_o   = dz_q;

endmodule

// File: tb/tb_div_16by16.sv
// Directed-vector bench for div_16by16: table of hand-computed divisions plus protocol,
// back-to-back, reset-abort and model-checked random sequences.
module tb_div_16by16;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic [15:0] dividend_i;
   logic [15:0] divisor_i;
   logic [15:0] quot_o;
   logic [15:0] rem_o;
   logic        busy_o;
   logic        done_o;
   logic        dz_o;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   div_16by16 dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .quot_o     (quot_o),
      .rem_o      (rem_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .dz_o       (dz_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Issue one start pulse and follow the operation to its done pulse.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r, input logic dz);
      int lat;
      int nbusy;
      bit both;
      @(posedge clk_i); #1;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat   = 1;
      nbusy = 0;
      both  = 1'b0;
      while (1) begin
         if (busy_o) nbusy++;
         if (busy_o && done_o) both = 1'b1;
         if (done_o || lat >= 40) break;
         @(posedge clk_i); #1;
         lat++;
      end
      chk({name, "_done"}, done_o, 1'b1);
      chk({name, "_lat"}, lat, (b == 16'd0) ? 1 : 17);
      chk({name, "_busycyc"}, nbusy, (b == 16'd0) ? 0 : 16);
      chk({name, "_overlap"}, both, 1'b0);
      chk({name, "_quot"}, quot_o, q);
      chk({name, "_rem"}, rem_o, r);
      chk({name, "_dz"}, dz_o, dz);
      @(posedge clk_i); #1;
      chk({name, "_pulse"}, done_o, 1'b0);
   endtask

   initial begin
      int lat;
      bit seen;
      logic [15:0] ra;
      logic [15:0] rb;

      vecs[0]  = '{16'd1000,  16'd7,     16'd142,   16'd6,    1'b0};
      vecs[1]  = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,    1'b0};
      vecs[2]  = '{16'd5,     16'hFFFF,  16'd0,     16'd5,    1'b0};
      vecs[3]  = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    1'b0};
      vecs[4]  = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1};
      vecs[5]  = '{16'd100,   16'd10,    16'd10,    16'd0,    1'b0};
      vecs[6]  = '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0};
      vecs[7]  = '{16'hFFFF,  16'd256,   16'd255,   16'd255,  1'b0};
      vecs[8]  = '{16'd40000, 16'd3,     16'd13333, 16'd1,    1'b0};
      vecs[9]  = '{16'd7,     16'd7,     16'd1,     16'd0,    1'b0};
      vecs[10] = '{16'd1,     16'd2,     16'd0,     16'd1,    1'b0};
      vecs[11] = '{16'd12345, 16'd123,   16'd100,   16'd45,   1'b0};

      rst_i      = 1'b1;
      start_i    = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      #2;
      chk("rst_quot", quot_o, 16'd0);
      chk("rst_rem", rem_o, 16'd0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_dz", dz_o, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
      end

      // Results hold across idle cycles.
      repeat (3) @(posedge clk_i);
      #1;
      chk("hold_idle_quot", quot_o, 16'd100);
      chk("hold_idle_rem", rem_o, 16'd45);

      // Mid-run start pulse and operand changes are ignored.
      @(posedge clk_i); #1;
      dividend_i = 16'd1000;
      divisor_i  = 16'd7;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat = 1;
      while (!done_o && lat < 40) begin
         if (lat == 5) begin
            chk("hold_run_quot", quot_o, 16'd100);
            start_i    = 1'b1;
            dividend_i = 16'd9;
            divisor_i  = 16'd3;
         end
         if (lat == 6) start_i = 1'b0;
         @(posedge clk_i); #1;
         lat++;
      end
      chk("midrun_lat", lat, 17);
      chk("midrun_quot", quot_o, 16'd142);
      chk("midrun_rem", rem_o, 16'd6);

      // Start held high through DONE chains a second operation with no idle cycle.
      @(posedge clk_i); #1;
      dividend_i = 16'd200;
      divisor_i  = 16'd9;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      dividend_i = 16'd50;
      divisor_i  = 16'd5;
      lat = 1;
      while (!done_o && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      chk("b2b_a_lat", lat, 17);
      chk("b2b_a_quot", quot_o, 16'd22);
      chk("b2b_a_rem", rem_o, 16'd2);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("b2b_busy", busy_o, 1'b1);
      lat = 1;
      while (!done_o && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      chk("b2b_b_lat", lat, 17);
      chk("b2b_b_quot", quot_o, 16'd10);
      chk("b2b_b_rem", rem_o, 16'd0);

      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom_range(0, 65535));
         if (i % 8 == 0) rb = 16'd0;
         else if (i % 3 == 1) rb = 16'($urandom_range(1, 255));
         else rb = 16'($urandom_range(1, 65535));
         if (rb == 16'd0) run_op($sformatf("rnd%0d", i), ra, rb, 16'hFFFF, ra, 1'b1);
         else run_op($sformatf("rnd%0d", i), ra, rb, ra / rb, ra % rb, 1'b0);
      end

      // Asynchronous reset in the middle of RUN aborts with no done pulse.
      run_op("pre_abort", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
      @(posedge clk_i); #1;
      dividend_i = 16'd1000;
      divisor_i  = 16'd7;
      start_i    = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (7) @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      chk("abort_quot", quot_o, 16'd0);
      chk("abort_rem", rem_o, 16'd0);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_done", done_o, 1'b0);
      chk("abort_dz", dz_o, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      seen  = 1'b0;
      repeat (20) begin
         @(posedge clk_i); #1;
         if (done_o || busy_o) seen = 1'b1;
      end
      chk("abort_quiet", seen, 1'b0);
      chk("abort_quot_hold", quot_o, 16'd0);
      run_op("post_abort", 16'd100, 16'd10, 16'd10, 16'd0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
